// File: rtl/rip_csr_unit.sv
// Machine-mode CSR unit: CSR read-modify-write, ECALL/EBREAK/MRET/illegal traps, PC redirect.
// Optional 64-bit mcycle/minstret counters are enabled with `define RIP_CSR_COUNTERS_EN.
`timescale 1ns/1ps

package rip_type;
   typedef struct packed {
      logic ecall;
      logic ebreak;
      logic mret;
      logic csrrw;
      logic csrrs;
      logic csrrc;
      logic csrrwi;
      logic csrrsi;
      logic csrrci;
   } inst_t;

   typedef struct packed {
      logic [31:0] mstatus;
      logic [31:0] mtvec;
      logic [31:0] mepc;
      logic [31:0] mcause;
   } csr_t;
endpackage

module rip_csr_unit #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  rip_type::inst_t   inst,
   input  logic [31:0]       pc,
   input  logic [11:0]       csr_addr,
   input  logic [4:0]        rs1_idx,
   input  logic [31:0]       rs1_data,
   input  logic              retire,
   output logic [31:0]       rdata,
   output logic              rdata_valid,
   output rip_type::csr_t    csr,
   output logic              trap_valid,
   output logic [31:0]       trap_pc
);

   typedef enum logic {ST_READY = 1'b0, ST_REDIRECT = 1'b1} state_e;

   state_e      state_q, state_d;
   logic        mie_q, mie_d, mpie_q, mpie_d;
   logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic [31:0] rdata_q, rdata_d, trap_pc_q, trap_pc_d;
   logic        rdata_valid_q, rdata_valid_d, trap_valid_q, trap_valid_d;

   logic        csr_op_s, imm_s, wr_en_s, mapped_s, ro_s, illegal_s, trap_s;
   logic [31:0] src_s, old_s, new_s, cause_s, mstatus_s;

`ifdef RIP_CSR_COUNTERS_EN
   logic [63:0] mcycle_q, minstret_q;
   logic        unused_s;
   assign unused_s = ^pc[1:0];

   // Free-running counters; reads see the value before this cycle's increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle_q   <= 64'd0;
         minstret_q <= 64'd0;
      end else begin
         mcycle_q   <= mcycle_q + 64'd1;
         minstret_q <= minstret_q + {63'd0, retire};
      end
   end
`else
   logic        unused_s;
   assign unused_s = ^{pc[1:0], retire};
`endif

   assign mstatus_s = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

   // Operand selection, read mux and the read-modify-write value.
   always_comb begin
      csr_op_s = inst.csrrw | inst.csrrs | inst.csrrc | inst.csrrwi | inst.csrrsi | inst.csrrci;
      imm_s    = inst.csrrwi | inst.csrrsi | inst.csrrci;
      src_s    = imm_s ? {27'd0, rs1_idx} : rs1_data;
      wr_en_s  = inst.csrrw | inst.csrrwi | (rs1_idx != 5'd0);
      mapped_s = 1'b1;
      ro_s     = 1'b0;
      case (csr_addr)
         12'h300: old_s = mstatus_s;
         12'h305: old_s = mtvec_q;
         12'h341: old_s = mepc_q;
         12'h342: old_s = mcause_q;
`ifdef RIP_CSR_COUNTERS_EN
         12'hB00: begin old_s = mcycle_q[31:0];    ro_s = 1'b1; end
         12'hB80: begin old_s = mcycle_q[63:32];   ro_s = 1'b1; end
         12'hB02: begin old_s = minstret_q[31:0];  ro_s = 1'b1; end
         12'hB82: begin old_s = minstret_q[63:32]; ro_s = 1'b1; end
`endif
         default: begin old_s = 32'd0; mapped_s = 1'b0; end
      endcase
      illegal_s = csr_op_s & (~mapped_s | (ro_s & wr_en_s));
      if (inst.csrrw | inst.csrrwi) begin
         new_s = src_s;
      end else if (inst.csrrs | inst.csrrsi) begin
         new_s = old_s | src_s;
      end else begin
         new_s = old_s & ~src_s;
      end
   end

   // Next-state: priority ECALL > EBREAK > MRET > illegal > CSR op; REDIRECT squashes input.
   always_comb begin
      state_d       = state_q;
      mie_d         = mie_q;
      mpie_d        = mpie_q;
      mtvec_d       = mtvec_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      trap_valid_d  = 1'b0;
      trap_pc_d     = trap_pc_q;
      trap_s        = 1'b0;
      cause_s       = 32'd0;
      if (state_q == ST_REDIRECT) begin
         state_d = ST_READY;
      end else if (valid) begin
         if (inst.ecall) begin
            trap_s  = 1'b1;
            cause_s = 32'd11;
         end else if (inst.ebreak) begin
            trap_s  = 1'b1;
            cause_s = 32'd3;
         end else if (inst.mret) begin
            mie_d        = mpie_q;
            mpie_d       = 1'b1;
            trap_valid_d = 1'b1;
            trap_pc_d    = mepc_q;
            state_d      = ST_REDIRECT;
         end else if (illegal_s) begin
            trap_s  = 1'b1;
            cause_s = 32'd2;
         end else if (csr_op_s) begin
            rdata_valid_d = 1'b1;
            rdata_d       = old_s;
            if (wr_en_s) begin
               case (csr_addr)
                  12'h300: begin mie_d = new_s[3]; mpie_d = new_s[7]; end
                  12'h305: mtvec_d  = {new_s[31:2], 2'b00};
                  12'h341: mepc_d   = {new_s[31:2], 2'b00};
                  12'h342: mcause_d = new_s;
                  default: begin end
               endcase
            end else begin
            end
         end else begin
         end
         if (trap_s) begin
            mepc_d       = {pc[31:2], 2'b00};
            mcause_d     = cause_s;
            mpie_d       = mie_q;
            mie_d        = 1'b0;
            trap_valid_d = 1'b1;
            trap_pc_d    = {mtvec_q[31:2], 2'b00};
            state_d      = ST_REDIRECT;
         end else begin
         end
      end else begin
      end
   end

   // State and architectural register update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_READY;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         mtvec_q       <= {RESET_MTVEC[31:2], 2'b00};
         mepc_q        <= 32'd0;
         mcause_q      <= 32'd0;
         rdata_q       <= 32'd0;
         rdata_valid_q <= 1'b0;
         trap_valid_q  <= 1'b0;
         trap_pc_q     <= 32'd0;
      end else begin
         state_q       <= state_d;
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
         mtvec_q       <= mtvec_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         trap_valid_q  <= trap_valid_d;
         trap_pc_q     <= trap_pc_d;
      end
   end

   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign trap_valid  = trap_valid_q;
   assign trap_pc     = trap_pc_q;
   assign csr         = '{mstatus: mstatus_s, mtvec: mtvec_q, mepc: mepc_q, mcause: mcause_q};

endmodule

// File: tb/tb_rip_csr_unit.sv
// Scoreboard bench for rip_csr_unit: directed CSR ops and traps, monitor checks rdata/trap pulses.
`timescale 1ns/1ps

module tb_rip_csr_unit;
   import rip_type::*;

   localparam inst_t I_ECALL   = 9'b100000000;
   localparam inst_t I_EBREAK  = 9'b010000000;
   localparam inst_t I_ECEB    = 9'b110000000;
   localparam inst_t I_MRET    = 9'b001000000;
   localparam inst_t I_MRET_RW = 9'b001100000;
   localparam inst_t I_RW      = 9'b000100000;
   localparam inst_t I_RS      = 9'b000010000;
   localparam inst_t I_RC      = 9'b000001000;
   localparam inst_t I_RSI     = 9'b000000010;
   localparam inst_t I_RCI     = 9'b000000001;
`ifdef RIP_CSR_COUNTERS_EN
   localparam logic [31:0] MC0 = 32'd2;
`else
   localparam logic [31:0] MC0 = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst, valid, retire;
   inst_t       inst;
   logic [31:0] pc, rs1_data, rdata, trap_pc;
   logic [11:0] csr_addr;
   logic [4:0]  rs1_idx;
   logic        rdata_valid, trap_valid;
   csr_t        csr;

   rip_csr_unit #(.RESET_MTVEC(32'h0000_0403)) dut (
      .clk(clk), .rst(rst), .valid(valid), .inst(inst), .pc(pc),
      .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_data(rs1_data), .retire(retire),
      .rdata(rdata), .rdata_valid(rdata_valid), .csr(csr),
      .trap_valid(trap_valid), .trap_pc(trap_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_trap;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // Monitor: every output pulse must match the oldest pending expectation.
   exp_t e;
   always @(negedge clk) begin
      if (rdata_valid || trap_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: rdata_valid=%b trap_valid=%b want none", rdata_valid, trap_valid);
         end else begin
            e = exp_q.pop_front();
            chk({e.name, "_both"}, {31'd0, rdata_valid & trap_valid}, 32'd0);
            chk({e.name, "_kind"}, {31'd0, trap_valid}, {31'd0, e.is_trap});
            chk(e.name, trap_valid ? trap_pc : rdata, e.val);
         end
      end
   end

   // kind: 0 = no output expected, 1 = rdata expected, 2 = trap redirect expected
   task automatic issue(input inst_t i, input logic [11:0] a, input logic [4:0] idx,
                        input logic [31:0] d, input logic [31:0] p,
                        input int kind, input logic [31:0] ev, input string name);
      exp_t x;
      valid = 1'b1; inst = i; csr_addr = a; rs1_idx = idx; rs1_data = d; pc = p;
      x.is_trap = (kind == 2); x.val = ev; x.name = name;
      if (kind != 0) exp_q.push_back(x);
      @(negedge clk);
      valid = 1'b0; inst = '0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_rdata"},       rdata,              32'd0);
      chk({tag, "_rdata_valid"}, {31'd0, rdata_valid}, 32'd0);
      chk({tag, "_trap_valid"},  {31'd0, trap_valid},  32'd0);
      chk({tag, "_trap_pc"},     trap_pc,            32'd0);
      chk({tag, "_mstatus"},     csr.mstatus,        32'h0000_1800);
      chk({tag, "_mtvec"},       csr.mtvec,          32'h0000_0400);
      chk({tag, "_mepc"},        csr.mepc,           32'd0);
      chk({tag, "_mcause"},      csr.mcause,         32'd0);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; inst = '0; pc = 32'd0; csr_addr = 12'd0;
      rs1_idx = 5'd0; rs1_data = 32'd0; retire = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;

`ifdef RIP_CSR_COUNTERS_EN
      for (int c = 0; c < 10; c++) begin
         retire = (c < 4);
         @(negedge clk);
      end
      retire = 1'b0;
      issue(I_RS, 12'hB00, 5'd0, 32'd0, 32'd0, 1, 32'd10, "mcycle_rd");
      issue(I_RS, 12'hB02, 5'd0, 32'd0, 32'd0, 1, 32'd4,  "minstret_rd");
      force dut.mcycle_q = 64'h0000_0000_FFFF_FFFF;
      @(negedge clk);
      release dut.mcycle_q;
      @(negedge clk);
      issue(I_RS, 12'hB80, 5'd0, 32'd0, 32'd0, 1, 32'd1, "mcycleh_carry");
      issue(I_RW, 12'hB00, 5'd1, 32'd5, 32'h40, 2, 32'h400, "mcycle_wr_trap");
      chk("mcycle_wr_cause", csr.mcause, 32'd2);
      @(negedge clk);
`endif

      issue(I_RW,  12'h305, 5'd5, 32'h8000_0103, 32'h10, 1, 32'h0000_0400, "rw_mtvec");
      chk("mtvec_masked", csr.mtvec, 32'h8000_0100);
      issue(I_RS,  12'h305, 5'd0, 32'hFFFF_FFFF, 32'h14, 1, 32'h8000_0100, "rs_nowrite");
      chk("mtvec_unchanged", csr.mtvec, 32'h8000_0100);
      issue(I_RSI, 12'h300, 5'd8, 32'd0, 32'h18, 1, 32'h0000_1800, "rsi_mstatus");
      chk("mstatus_set", csr.mstatus, 32'h0000_1808);
      issue(I_RCI, 12'h300, 5'd8, 32'd0, 32'h1C, 1, 32'h0000_1808, "rci_mstatus");
      chk("mstatus_clr", csr.mstatus, 32'h0000_1800);
      issue(I_RW,  12'h300, 5'd1, 32'hFFFF_FFFF, 32'h20, 1, 32'h0000_1800, "rw_mstatus");
      chk("mstatus_ones", csr.mstatus, 32'h0000_1888);
      issue(I_RW,  12'h342, 5'd2, 32'hDEAD_BEEF, 32'h24, 1, MC0, "rw_mcause");
      chk("mcause_full", csr.mcause, 32'hDEAD_BEEF);
      issue(I_RC,  12'h342, 5'd3, 32'h0000_FFFF, 32'h28, 1, 32'hDEAD_BEEF, "rc_mcause");
      chk("mcause_rc", csr.mcause, 32'hDEAD_0000);
      issue(I_RW,  12'h305, 5'd4, 32'h0000_0200, 32'h2C, 1, 32'h8000_0100, "rw_mtvec2");

      issue(I_ECALL, 12'h000, 5'd0, 32'd0, 32'h100, 2, 32'h200, "ecall_redirect");
      chk("ecall_mepc",    csr.mepc,    32'h100);
      chk("ecall_mcause",  csr.mcause,  32'd11);
      chk("ecall_mstatus", csr.mstatus, 32'h0000_1880);
      issue(I_RW, 12'h342, 5'd1, 32'h55, 32'h104, 0, 32'd0, "squashed");
      chk("squash_mcause", csr.mcause, 32'd11);
      issue(I_MRET, 12'h000, 5'd0, 32'd0, 32'h108, 2, 32'h100, "mret_redirect");
      chk("mret_mstatus", csr.mstatus, 32'h0000_1888);
      @(negedge clk);

      issue(I_RW, 12'h7C0, 5'd1, 32'd1, 32'h140, 2, 32'h200, "illegal_redirect");
      chk("illegal_mcause", csr.mcause, 32'd2);
      chk("illegal_mepc",   csr.mepc,   32'h140);
      chk("illegal_mstatus", csr.mstatus, 32'h0000_1880);
      @(negedge clk);
      issue(I_ECEB, 12'h000, 5'd0, 32'd0, 32'h180, 2, 32'h200, "ecall_ebreak");
      chk("prio_mcause", csr.mcause, 32'd11);
      @(negedge clk);
`ifndef RIP_CSR_COUNTERS_EN
      issue(I_RS, 12'hB00, 5'd0, 32'd0, 32'h1C0, 2, 32'h200, "nocounter_trap");
      chk("nocounter_mcause", csr.mcause, 32'd2);
      @(negedge clk);
`endif
      issue(I_EBREAK, 12'h000, 5'd0, 32'd0, 32'h184, 2, 32'h200, "ebreak_redirect");
      chk("ebreak_mcause", csr.mcause, 32'd3);
      @(negedge clk);
      issue(I_RW, 12'h341, 5'd1, 32'h0000_1237, 32'h188, 1, 32'h184, "rw_mepc");
      chk("mepc_masked", csr.mepc, 32'h0000_1234);
      issue(I_MRET_RW, 12'h342, 5'd1, 32'h77, 32'h18C, 2, 32'h1234, "mret_over_csr");
      chk("mret_prio_mcause", csr.mcause, 32'd3);
      chk("mret_prio_mstatus", csr.mstatus, 32'h0000_1880);
      @(negedge clk);

      issue(I_ECALL, 12'h000, 5'd0, 32'd0, 32'h1F0, 2, 32'h200, "ecall_pre_reset");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state("mid_redirect_reset");
      issue(I_RS, 12'h300, 5'd0, 32'd0, 32'h0, 1, 32'h0000_1800, "post_reset_read");

      repeat (3) @(negedge clk);
      chk("pending_expectations", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rip_csr_unit.md
# rip_csr_unit

Machine-mode CSR unit for the rip-cpu core. It owns the architectural CSRs that the rest of the pipeline consumes as a packed `csr_t`, and executes the CSR instructions CSRRW/S/C and CSRRWI/SI/CI. It also executes the trap instructions ECALL/EBREAK/MRET and illegal CSR accesses, and produces a one-cycle PC-redirect request. It sits in the execute stage, fed by the decoded `inst_t` flags and the register-read operands.

## Interface
Parameters:
- `RESET_MTVEC`, 32'h0000_0000: reset value of mtvec.

Ports:
- `clk`, in, 1: clock. The block uses this single clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `valid`, in, 1: the instruction on `inst` is valid this cycle.
- `inst`, in, `rip_type::inst_t`: decoded instruction flags.
- `pc`, in, 32: PC of the instruction.
- `csr_addr`, in, 12: CSR address field (inst[31:20]).
- `rs1_idx`, in, 5: rs1 index; holds uimm for the *I variants.
- `rs1_data`, in, 32: rs1 operand.
- `retire`, in, 1: one instruction retired this cycle. Used only for counters.
- `rdata`, out, 32: old CSR value, for rd writeback.
- `rdata_valid`, out, 1: `rdata` is valid.
- `csr`, out, `rip_type::csr_t`: current mstatus, mtvec, mepc, mcause.
- `trap_valid`, out, 1: redirect request, single-cycle pulse.
- `trap_pc`, out, 32: redirect target.

## Operation
- Address map:
  - mstatus 0x300
  - mtvec 0x305
  - mepc 0x341
  - mcause 0x342
  - With counters only: mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
- Unmapped address = illegal access.
- Field rules:
  - mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] is hardwired 2'b11. All other bits read 0.
  - mtvec and mepc: bits[1:0] are hardwired 0.
  - mcause: full 32 bits writable.
- Operand: `src` = `rs1_data` for register variants, zero-extended `rs1_idx` for *I variants.
- New value:
  - RW: `src`.
  - RS: `old | src`.
  - RC: `old & ~src`.
- CSRRS/C/SI/CI with `rs1_idx==0` perform no write. The read still occurs.
- CSRRW/WI always write.
- Counter CSRs are read-only. A write to them is an illegal access.
- Priority when several flags are set with `valid`: ECALL > EBREAK > MRET > illegal CSR > CSR op. Only the highest-priority action occurs.
- Trap entry (ECALL cause 11, EBREAK cause 3, illegal CSR cause 2):
  - mepc <= `pc`.
  - mcause <= cause.
  - MPIE <= MIE, MIE <= 0.
  - `trap_pc` = {mtvec[31:2], 2'b00}.
  - A trapping instruction does not assert `rdata_valid`.
- MRET: MIE <= MPIE, MPIE <= 1, `trap_pc` = mepc (pre-update value).
- FSM with two states:
  - READY: normal operation.
  - REDIRECT: entered on any trap or MRET. Lasts exactly one cycle, during which `trap_valid` = 1. Any `valid` input is squashed (no CSR effect, no `rdata_valid`). Returns to READY unconditionally.

## Timing
- All state updates occur at the `clk` edge where `valid` is sampled in READY.
- `rdata`/`rdata_valid` are registered: 1-cycle latency after the accepted CSR op. `rdata` is the value before the write.
- `csr` is driven directly from the registers. A write is visible the cycle after acceptance.
- `trap_valid`/`trap_pc` are registered: asserted the cycle after the trap or MRET is accepted, for exactly 1 cycle.
- Back-to-back CSR ops in consecutive READY cycles are accepted every cycle. The second op sees the first op's written value.
- Reset (`rst` high at an edge) overrides everything, including REDIRECT in progress. Reset values:
  - state READY
  - mstatus 32'h0000_1800
  - mtvec `RESET_MTVEC` with [1:0] cleared
  - mepc 0
  - mcause 0
  - counters 0
  - `rdata` 0, `rdata_valid` 0
  - `trap_valid` 0, `trap_pc` 0

## Configuration
- `RIP_CSR_COUNTERS_EN`, when defined, adds two 64-bit counters:
  - mcycle: +1 every cycle not in reset.
  - minstret: +1 when `retire`=1.
  - Both wrap modulo 2^64.
  - The low and high halves are readable at the addresses above. Reading a half returns the value before this cycle's increment.
- When undefined: no counter registers exist, `retire` is ignored, and 0xB00/0xB80/0xB02/0xB82 are illegal (cause 2).

## Test plan
- CSR write/read: CSRRW 0x305 with `rs1_data`=32'h8000_0103. Required: next cycle `rdata`=old value, `csr.mtvec`=32'h8000_0100. A following CSRRS 0x305 with rs1_idx=0 returns 32'h8000_0100 and performs no write.
- Immediate set/clear: CSRRSI 0x300 uimm=8 -> mstatus=32'h0000_1808. Then CSRRCI 0x300 uimm=8 -> 32'h0000_1800. A write of 32'hFFFF_FFFF -> 32'h0000_1888.
- Trap and return: ECALL at pc=32'h100 with mtvec=32'h200 and MIE=1. Required: mepc=32'h100, mcause=11, MIE=0, MPIE=1, a 1-cycle `trap_valid` with `trap_pc`=32'h200. A `valid` CSRRW presented in the REDIRECT cycle has no effect. A later MRET yields `trap_pc`=32'h100, MIE=1.
- Illegal/priority: CSRRW to 0x7C0 -> mcause=2, no `rdata_valid`. ECALL and EBREAK both set -> mcause=11.
- Counters (macro defined): 10 cycles after reset release with `retire` high on 4 of them, reads of 0xB00 and 0xB02 return 10 and 4 (±the defined pre-increment point). A write to 0xB00 traps with cause 2. Preload via force to 32'hFFFF_FFFF low -> mcycleh increments.
- Reset mid-REDIRECT: assert `rst` in the REDIRECT cycle. Required: next cycle `trap_valid`=0 and all outputs at reset values.
